// File: rtl/instr_decode_stage.sv
// instr_decode_stage: registered RV32I/RV64I decode stage.
// Splits the fetched word into raw fields, picks and sign-extends the
// immediate for the instruction format, flags register usage and illegal
// encodings, and buffers the result behind valid/ready handshakes.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   flush               drop every held and incoming instruction this cycle
//   in_valid/in_ready   upstream handshake; in_instr (32b), in_pc (XLEN)
//   out_valid/out_ready downstream handshake
//   out_pc              registered copy of in_pc
//   out_opcode..func7   raw instruction fields
//   out_imm, out_fmt    format-selected immediate and format code
//   out_rd_we, out_rs1_used, out_rs2_used, out_illegal  decode flags
//
// SKID=1: main register + one skid entry, in_ready straight from a flop.
// SKID=0: single register, in_ready combinational from out_ready.
module instr_decode_stage #(
  parameter int XLEN = 32,
  parameter int SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_func3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_func7,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_rd_we,
  output logic            out_rs1_used,
  output logic            out_rs2_used,
  output logic            out_illegal
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  // One decoded bundle; raw fields are sliced from instr at the output.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic            rd_we;
    logic            rs1_used;
    logic            rs2_used;
    logic            illegal;
  } bundle_t;

  // Widest legal store func3: SW on RV32, SD on RV64.
  localparam logic [2:0] ST_F3_MAX = (XLEN == 64) ? 3'd3 : 3'd2;

  bundle_t dec;
  bundle_t main_q;
  logic    main_vld;
  logic    accept;

  fmt_e    fmt;
  logic    ill;
  logic    is_op;   // OP / OP-32: the only R-format users of rd/rs1/rs2
  logic    is_sys;  // SYSTEM: I-format that does not read rs1
  logic [XLEN-1:0] imm;

  assign accept = in_valid & in_ready;

  // ---------------- combinational decode ----------------
  always_comb begin
    fmt    = FMT_R;
    ill    = 1'b0;
    is_op  = 1'b0;
    is_sys = 1'b0;
    imm    = '0;

    case (in_instr[6:0])
      7'b0110111, 7'b0010111: fmt = FMT_U;              // LUI, AUIPC
      7'b1101111:             fmt = FMT_J;              // JAL
      7'b1100111: begin                                 // JALR
        fmt = FMT_I;
        ill = (in_instr[14:12] != 3'b000);
      end
      7'b0000011, 7'b0010011: fmt = FMT_I;              // LOAD, OP-IMM
      7'b1110011: begin                                 // SYSTEM
        fmt    = FMT_I;
        is_sys = 1'b1;
      end
      7'b0100011: begin                                 // STORE
        fmt = FMT_S;
        ill = (in_instr[14:12] > ST_F3_MAX);
      end
      7'b1100011: begin                                 // BRANCH
        fmt = FMT_B;
        ill = (in_instr[14:13] == 2'b01);               // func3 010/011
      end
      7'b0110011:             is_op = 1'b1;             // OP
      7'b0001111:             fmt = FMT_R;              // MISC-MEM
      7'b0011011: begin                                 // OP-IMM-32
        if (XLEN == 64) fmt = FMT_I;
        else            ill = 1'b1;
      end
      7'b0111011: begin                                 // OP-32
        if (XLEN == 64) is_op = 1'b1;
        else            ill = 1'b1;
      end
      default:                ill = 1'b1;
    endcase

    if (in_instr[1:0] != 2'b11) ill = 1'b1;

    // Width casts of signed values sign-extend from instr[31] to XLEN.
    case (fmt)
      FMT_I: imm = XLEN'($signed(in_instr[31:20]));
      FMT_S: imm = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
      FMT_B: imm = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
      FMT_U: imm = XLEN'($signed({in_instr[31:12], 12'b0}));
      FMT_J: imm = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));
      default: imm = '0;
    endcase

    dec          = '0;
    dec.pc       = in_pc;
    dec.instr    = in_instr;
    dec.illegal  = ill;
    // Illegal words keep raw fields but carry no format, immediate or usage.
    if (!ill) begin
      dec.fmt      = fmt;
      dec.imm      = imm;
      dec.rd_we    = (is_op || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J)
                     && (in_instr[11:7] != 5'd0);
      dec.rs1_used = is_op || (fmt == FMT_I && !is_sys)
                     || fmt == FMT_S || fmt == FMT_B;
      dec.rs2_used = is_op || fmt == FMT_S || fmt == FMT_B;
    end
  end

  // ---------------- storage ----------------
  if (SKID != 0) begin : g_skid
    bundle_t skid_q;
    logic    skid_vld;

    assign in_ready = !skid_vld;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_q   <= '0;
        main_vld <= 1'b0;
        skid_q   <= '0;
        skid_vld <= 1'b0;
      end else if (flush) begin
        main_vld <= 1'b0;
        skid_vld <= 1'b0;
      end else if (!main_vld || out_ready) begin
        // Main slot frees up: the older skid entry goes first. No input can
        // be accepted while skid is full, so nothing is lost here.
        if (skid_vld) begin
          main_q   <= skid_q;
          main_vld <= 1'b1;
          skid_vld <= 1'b0;
        end else begin
          main_vld <= accept;
          if (accept) main_q <= dec;
        end
      end else if (accept) begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end
  end else begin : g_single
    assign in_ready = !main_vld || out_ready;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_q   <= '0;
        main_vld <= 1'b0;
      end else if (flush) begin
        main_vld <= 1'b0;
      end else if (in_ready) begin
        main_vld <= accept;
        if (accept) main_q <= dec;
      end
    end
  end

  // ---------------- outputs ----------------
  assign out_valid    = main_vld;
  assign out_pc       = main_q.pc;
  assign out_opcode   = main_q.instr[6:0];
  assign out_rd       = main_q.instr[11:7];
  assign out_func3    = main_q.instr[14:12];
  assign out_rs1      = main_q.instr[19:15];
  assign out_rs2      = main_q.instr[24:20];
  assign out_func7    = main_q.instr[31:25];
  assign out_imm      = main_q.imm;
  assign out_fmt      = main_q.fmt;
  assign out_rd_we    = main_q.rd_we;
  assign out_rs1_used = main_q.rs1_used;
  assign out_rs2_used = main_q.rs2_used;
  assign out_illegal  = main_q.illegal;

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Registered RV32I/RV64I decode stage. Splits a fetched instruction into fields, selects and sign-extends the single correct immediate for the instruction format, and flags register usage and illegal encodings. Sits between fetch and issue, with valid/ready handshakes on both sides, optional skid buffering and a pipeline flush.

## Interface
- XLEN, 32: datapath width; 32 or 64. Sets immediate and PC width.
- SKID, 1: 1 = two-entry skid buffer with registered `in_ready`; 0 = single register with combinational `in_ready`.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discards all held and incoming instructions this cycle.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept an instruction.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address; passed through unchanged.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  downstream accepts the bundle.
- out_pc  out  XLEN  registered copy of `in_pc`.
- out_opcode, out_rd, out_func3, out_rs1, out_rs2, out_func7  out  7/5/3/5/5/7  raw fields: [6:0], [11:7], [14:12], [19:15], [24:20], [31:25].
- out_imm  out  XLEN  format-selected immediate, sign-extended from instr[31].
- out_fmt  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J.
- out_rd_we, out_rs1_used, out_rs2_used  out  1  register usage flags.
- out_illegal  out  1  encoding not supported.

## Operation
- Format by opcode:
  - LUI 0110111 and AUIPC 0010111 are U.
  - JAL 1101111 is J.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011 and SYSTEM 1110011 are I.
  - STORE 0100011 is S.
  - BRANCH 1100011 is B.
  - OP 0110011 and MISC-MEM 0001111 are R/none.
  - XLEN=64 additionally accepts OP-IMM-32 0011011 (I) and OP-32 0111011 (R).
- Immediates:
  - I = instr[31:20].
  - S = {instr[31:25], instr[11:7]}.
  - B = {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U = {instr[31:12], 12'b0}.
  - J = {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All are sign-extended to XLEN; U is also sign-extended on XLEN=64.
  - R/none gives 0.
- Usage flags:
  - `rd_we` = format in {R(OP/OP-32 only), I, U, J} and rd≠0.
  - `rs1_used` = format in {R(OP/OP-32), I except SYSTEM, S, B}.
  - `rs2_used` = format in {R(OP/OP-32), S, B}.
- Illegal:
  - Set when instr[1:0]≠11, or the opcode is not in the list above.
  - Set when JALR func3≠000, when BRANCH func3 is 010 or 011, or when STORE func3>010 (>011 on XLEN=64).
  - When illegal: `out_fmt`=0, `out_imm`=0, and all three usage flags are 0. The raw fields still reflect the instruction word.
- Storage with SKID=0:
  - One entry.
  - `in_ready` = !out_valid | out_ready.
- Storage with SKID=1:
  - A main register drives the outputs; a skid register holds one extra entry.
  - `in_ready` = !skid_valid, taken directly from the flop.
  - If an entry is accepted while the main register is valid and `out_ready`=0, it goes into the skid register.
  - When the main register drains and the skid register is valid, the skid entry moves into the main register.
  - Order is strictly FIFO.
- Flush:
  - Clears `out_valid` and `skid_valid` at the next edge.
  - An input handshake in the same cycle is discarded.
  - Takes priority over all other updates.

## Timing
- Latency: bundle appears on outputs 1 cycle after the `in_valid & in_ready` edge.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- Reset: every output register is 0, including `out_valid`=0, `out_illegal`=0 and `out_fmt`=0. `skid_valid`=0. `in_ready`=1 after reset with either SKID value.
- Output stability: while `out_valid`=1 and `out_ready`=0, all `out_*` signals hold stable.
- Skid full: with SKID=1 and both entries full, `in_ready`=0. When the main entry drains, `in_ready` returns to 1 at the following edge.
- Reset asserted mid-stream drops every held entry asynchronously; no partial bundle is presented afterwards.

## Test plan
- ADDI x1,x0,-1 (0xFFF00093), XLEN=32: one cycle later, `out_fmt`=1, `out_imm`=0xFFFFFFFF, `out_rd`=1, `out_rd_we`=1, `out_rs1_used`=1, `out_rs2_used`=0.
- Immediate formats:
  - SW x2,8(x1) (0x0020A423): `out_fmt`=2, `out_imm`=0x00000008, `out_rd_we`=0, `out_rs2_used`=1.
  - BEQ x0,x0,-4 (0xFE000EE3): `out_fmt`=3, `out_imm`=0xFFFFFFFC.
  - JAL x1,+2048 (0x001000EF): `out_fmt`=5, `out_imm`=0x00000800.
- XLEN=64, LUI x1,0x80000 (0x800000B7): `out_imm`=0xFFFFFFFF80000000, `out_fmt`=4.
- Illegal inputs 0x00000000 and JALR with func3=001: `out_illegal`=1, `out_fmt`=0, `out_imm`=0, `out_rd_we`=0.
- SKID=1 backpressure: hold `out_ready`=0 and offer instructions A, B, C on consecutive cycles. A and B are accepted; `in_ready`=0 while C is offered. Then raise `out_ready`: the outputs present A, B, C in order, with no loss and no duplicates.
- Flush and reset: with both entries full, assert `flush` for one cycle together with `in_valid`. Next cycle `out_valid`=0 and `in_ready`=1. Separately, assert `rst` mid-stream: all outputs go to 0 immediately, without waiting for a clock edge.
